// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between IFU fetches and LSU loads/stores, one request in flight.
// Define MEM_ARB_RR_EN for round-robin grant on simultaneous requests; default is fixed LSU > IFU.
module mem_arbiter #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_lsu_q, owner_lsu_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
`ifdef MEM_ARB_RR_EN
    logic        prefer_lsu_q, prefer_lsu_d;
`endif

    logic grant_lsu, grant_ifu, idle_ok, accept, access;

    always_comb begin
`ifdef MEM_ARB_RR_EN
        if (lsu_req_valid && ifu_req_valid) begin
            grant_lsu = prefer_lsu_q;
        end else begin
            grant_lsu = lsu_req_valid;
        end
`else
        grant_lsu = lsu_req_valid;
`endif
        grant_ifu = ifu_req_valid && !grant_lsu;
    end

    // Ready is gated by reset so that no requester sees ready while held in reset.
    assign idle_ok       = (state_q == S_IDLE) && reset;
    assign lsu_req_ready = idle_ok && grant_lsu;
    assign ifu_req_ready = idle_ok && grant_ifu;
    assign accept        = lsu_req_ready || ifu_req_ready;
    assign access        = (state_q == S_ACCESS);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_lsu_d = owner_lsu_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
`ifdef MEM_ARB_RR_EN
        prefer_lsu_d = prefer_lsu_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_WAIT;
                    cnt_d       = 4'(LATENCY);
                    owner_lsu_d = grant_lsu;
                    addr_d      = grant_lsu ? lsu_addr : ifu_addr;
                    wen_d       = grant_lsu && lsu_wen;
                    wdata_d     = grant_lsu ? lsu_wdata : '0;
                    wmask_d     = grant_lsu ? lsu_wmask : '0;
`ifdef MEM_ARB_RR_EN
                    prefer_lsu_d = !grant_lsu;
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (owner_lsu_q) begin
                    lsu_rdata_d = wen_q ? '0 : mem_rdata;
                end else begin
                    ifu_rdata_d = mem_rdata;
                end
            end
            S_RESP: begin
                if (owner_lsu_q ? lsu_resp_ready : ifu_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            prefer_lsu_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_lsu_q <= owner_lsu_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
`ifdef MEM_ARB_RR_EN
            prefer_lsu_q <= prefer_lsu_d;
`endif
        end
    end

    // Memory strobes exist only in ACCESS, so a store produces exactly one write.
    assign mem_valid = access;
    assign mem_wen   = access && wen_q;
    assign mem_addr  = access ? addr_q  : '0;
    assign mem_wdata = access ? wdata_q : '0;
    assign mem_wmask = access ? wmask_q : '0;

    assign ifu_resp_valid = (state_q == S_RESP) && !owner_lsu_q;
    assign lsu_resp_valid = (state_q == S_RESP) && owner_lsu_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY=1 instance for handshake/arbitration, a LATENCY=4 instance for mid-WAIT reset.
module tb_mem_arbiter;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 4;

    typedef struct packed {
        logic        is_lsu;
        logic [31:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_valid, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    logic        b_ifu_req_ready, b_ifu_resp_valid;
    logic [31:0] b_ifu_rdata;
    logic        b_lsu_req_valid, b_lsu_req_ready, b_lsu_wen, b_lsu_resp_valid;
    logic [31:0] b_lsu_addr, b_lsu_wdata, b_lsu_rdata;
    logic [3:0]  b_lsu_wmask;
    logic        b_mem_valid, b_mem_wen;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_wmask;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sb[$];
    logic grant_log[$];
    int wr_cnt = 0;
    logic [31:0] last_addr = '0, last_wdata = '0;
    logic [3:0]  last_wmask = '0;
    int b_mv_cnt = 0;
    int b_resp_cnt = 0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign mem_rdata   = mem_model(mem_addr);
    assign b_mem_rdata = mem_model(b_mem_addr);

    mem_arbiter #(.LATENCY(LAT_A)) u_dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.LATENCY(LAT_B)) u_dut_b (
        .clock(clock), .reset(reset),
        .ifu_req_valid(1'b0), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(32'h0),
        .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_ready(1'b1), .ifu_rdata(b_ifu_rdata),
        .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_addr(b_lsu_addr),
        .lsu_wen(b_lsu_wen), .lsu_wdata(b_lsu_wdata), .lsu_wmask(b_lsu_wmask),
        .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(b_lsu_rdata),
        .mem_valid(b_mem_valid), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata)
    );

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input logic is_lsu, input logic [31:0] data);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow: observed response with lsu=%0d, expected none pending", is_lsu);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_owner", 32'(is_lsu), 32'(e.is_lsu));
            chk("resp_rdata", data, e.data);
        end
    endtask

    // Scoreboard: expected response queued at accept, popped at the response handshake.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (lsu_req_valid && lsu_req_ready) begin
                sb.push_back({1'b1, lsu_wen ? 32'h0 : mem_model(lsu_addr)});
                grant_log.push_back(1'b1);
            end
            if (ifu_req_valid && ifu_req_ready) begin
                sb.push_back({1'b0, mem_model(ifu_addr)});
                grant_log.push_back(1'b0);
            end
            chk("single_ready", 32'(ifu_req_ready & lsu_req_ready), 32'd0);
            if (mem_valid) begin
                if (mem_wen) begin
                    wr_cnt++;
                    last_addr  = mem_addr;
                    last_wdata = mem_wdata;
                    last_wmask = mem_wmask;
                end
            end else begin
                chk("mem_idle_zero", 32'({mem_wen, |mem_addr, |mem_wdata, |mem_wmask}), 32'd0);
            end
            if (ifu_resp_valid && ifu_resp_ready) pop_check(1'b0, ifu_rdata);
            if (lsu_resp_valid && lsu_resp_ready) pop_check(1'b1, lsu_rdata);
        end
    end

    always @(negedge clock) begin
        if (b_mem_valid) b_mv_cnt++;
        if (b_lsu_resp_valid) b_resp_cnt++;
    end

    function automatic logic resp_flag(input int which);
        case (which)
            0:       return ifu_resp_valid;
            1:       return lsu_resp_valid;
            default: return b_lsu_resp_valid;
        endcase
    endfunction

    task automatic wait_resp(input string tag, input int which, input int acc, output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (resp_flag(which)) begin
                seen = 1'b1;
                lat = cyc - acc;
                break;
            end
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL %s: observed no resp_valid in 40 cycles, expected resp_valid=1", tag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_ctl"}, 32'({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_valid, mem_wen}), 32'd0);
        chk({tag, "_a_ifu_rdata"}, ifu_rdata, 32'd0);
        chk({tag, "_a_lsu_rdata"}, lsu_rdata, 32'd0);
        chk({tag, "_a_mem_bus"}, mem_addr | mem_wdata | 32'(mem_wmask), 32'd0);
        chk({tag, "_b_ctl"}, 32'({b_ifu_req_ready, b_lsu_req_ready, b_ifu_resp_valid, b_lsu_resp_valid, b_mem_valid, b_mem_wen}), 32'd0);
        chk({tag, "_b_rdata"}, b_ifu_rdata | b_lsu_rdata, 32'd0);
        chk({tag, "_b_mem_bus"}, b_mem_addr | b_mem_wdata | 32'(b_mem_wmask), 32'd0);
    endtask

    initial begin
        int acc, lat, w0, g0;
        logic exp_g;
        reset = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = '0; ifu_resp_ready = 1'b1;
        lsu_req_valid = 1'b1; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0; lsu_resp_ready = 1'b1;
        b_lsu_req_valid = 1'b1; b_lsu_addr = '0; b_lsu_wen = 1'b0; b_lsu_wdata = '0; b_lsu_wmask = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("rst");
        @(posedge clock); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; b_lsu_req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;

        // IFU fetch, LATENCY=1
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        @(negedge clock);
        chk("t1_ifu_ready", 32'(ifu_req_ready), 32'd1);
        acc = cyc;
        @(posedge clock); #1;
        ifu_req_valid = 1'b0; ifu_addr = 32'hFFFF_FFF0;
        wait_resp("t1_resp", 0, acc, lat);
        chk("t1_latency", 32'(lat), LAT_A + 2);
        chk("t1_rdata", ifu_rdata, 32'h0000_0413);
        @(posedge clock); #1;

        // LSU store: one write strobe, zero read data
        w0 = wr_cnt;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        @(negedge clock);
        chk("t2_lsu_ready", 32'(lsu_req_ready), 32'd1);
        acc = cyc;
        @(posedge clock); #1;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        wait_resp("t2_resp", 1, acc, lat);
        chk("t2_latency", 32'(lat), LAT_A + 2);
        chk("t2_rdata", lsu_rdata, 32'd0);
        @(posedge clock); #1;
        chk("t2_write_pulses", 32'(wr_cnt - w0), 32'd1);
        chk("t2_waddr", last_addr, 32'h8000_1000);
        chk("t2_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("t2_wmask", 32'(last_wmask), 32'hF);

        // LSU load
        w0 = wr_cnt;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
        @(negedge clock);
        acc = cyc;
        @(posedge clock); #1;
        lsu_req_valid = 1'b0;
        wait_resp("t2b_resp", 1, acc, lat);
        chk("t2b_rdata", lsu_rdata, 32'h25A5_7A5A);
        @(posedge clock); #1;
        chk("t2b_no_write", 32'(wr_cnt - w0), 32'd0);

        // Simultaneous requests after reset: LSU first, IFU in the IDLE after the LSU response
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0020; lsu_wen = 1'b0;
        @(negedge clock);
        chk("t3_ready_pair", 32'({lsu_req_ready, ifu_req_ready}), 32'b10);
        acc = cyc;
        @(posedge clock); #1;
        lsu_req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ifu_req_ready) break;
        end
        chk("t3_ifu_ready", 32'(ifu_req_ready), 32'd1);
        chk("t3_ifu_gap", 32'(cyc - acc), LAT_A + 3);
        acc = cyc;
        @(posedge clock); #1;
        ifu_req_valid = 1'b0;
        wait_resp("t3_ifu_resp", 0, acc, lat);
        chk("t3_ifu_latency", 32'(lat), LAT_A + 2);
        @(posedge clock); #1;

        // Both held valid for four grants
        g0 = grant_log.size();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0030;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0034; lsu_wen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock); #1;
            if (grant_log.size() >= g0 + 4) break;
        end
        @(posedge clock); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        chk("t4_grant_count", 32'(grant_log.size() - g0), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_g = (i % 2 == 0);
`else
            exp_g = 1'b1;
`endif
            if (g0 + i < grant_log.size())
                chk($sformatf("t4_grant%0d_lsu", i), 32'(grant_log[g0 + i]), 32'(exp_g));
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock); #1;
            if (sb.size() == 0) break;
        end
        chk("t4_drained", 32'(sb.size()), 32'd0);
        @(posedge clock); #1;

        // Response backpressure
        ifu_resp_ready = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        @(negedge clock);
        chk("t5_ifu_ready", 32'(ifu_req_ready), 32'd1);
        acc = cyc;
        @(posedge clock); #1;
        ifu_req_valid = 1'b0;
        wait_resp("t5_resp", 0, acc, lat);
        @(posedge clock); #1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0050;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t5_hold_valid", 32'(ifu_resp_valid), 32'd1);
            chk("t5_hold_rdata", ifu_rdata, 32'h25A5_5A1A);
            chk("t5_hold_req_ready", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
        end
        @(posedge clock); #1;
        ifu_resp_ready = 1'b1; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(negedge clock);
        chk("t5_release_valid", 32'(ifu_resp_valid), 32'd1);
        @(negedge clock);
        chk("t5_after_release", 32'(ifu_resp_valid), 32'd0);
        @(posedge clock); #1;

        // Reset during WAIT of a store on the LATENCY=4 instance
        b_lsu_req_valid = 1'b1; b_lsu_addr = 32'h8000_3000; b_lsu_wen = 1'b1;
        b_lsu_wdata = 32'hCAFE_F00D; b_lsu_wmask = 4'h3;
        @(negedge clock);
        chk("t6_store_ready", 32'(b_lsu_req_ready), 32'd1);
        @(posedge clock); #1;
        b_lsu_req_valid = 1'b0; b_lsu_wen = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("t6_rst");
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (8) @(negedge clock);
        #1;
        chk("t6_no_mem_valid", 32'(b_mv_cnt), 32'd0);
        chk("t6_no_resp", 32'(b_resp_cnt), 32'd0);
        @(posedge clock); #1;
        b_lsu_req_valid = 1'b1; b_lsu_addr = 32'h8000_4000; b_lsu_wen = 1'b0;
        @(negedge clock);
        chk("t6_idle_ready", 32'(b_lsu_req_ready), 32'd1);
        acc = cyc;
        @(posedge clock); #1;
        b_lsu_req_valid = 1'b0;
        wait_resp("t6_load_resp", 2, acc, lat);
        chk("t6_latency", 32'(lat), LAT_B + 2);
        chk("t6_rdata", b_lsu_rdata, 32'h25A5_1A5A);
        #1;
        chk("t6_one_access", 32'(b_mv_cnt), 32'd1);
        @(posedge clock); #1;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
